// File: rtl/mem_stage_pkg.sv
// Shared constants for the pipeline: register file size, data memory map,
// default wait states and the memory-stage FSM state encoding.
package mem_stage_pkg;

  localparam int REG_FILE_DEPTH  = 15;
  localparam int MEM_BASE_ADDR   = 1024;
  localparam int MEM_DEPTH       = 64;
  localparam int MEM_WAIT_CYCLES = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_stage_data_memory.sv
// Word-addressed data memory: synchronous write, asynchronous read.
// Contents are not cleared by reset.
module data_memory #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Commit a word on the clock edge when write enable is high
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// Memory stage of the 5-stage pipeline. Performs LDR/STR against the data
// memory with WAIT_CYCLES extra cycles per access and drives ready, which
// the top level inverts into the global freeze.
//
// Handshake: a request (mem_read_in or mem_write_in) is held stable by
// upstream while ready = 0; the access completes in the single cycle where
// request and ready are both high, and a store commits on the edge that ends
// that cycle. A request still present afterwards is a new access.
//
// Optional feature: define MEM_BOUNDS_CHECK_EN to add the mem_err output,
// which flags out-of-range or misaligned accesses; such stores are dropped
// and such loads return 0. Without it addresses wrap and the low two bits
// are ignored.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DEPTH       = MEM_DEPTH,
  parameter int BASE_ADDR   = MEM_BASE_ADDR,
  parameter int WAIT_CYCLES = MEM_WAIT_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_en_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [31:0] alu_res_in,
  input  logic [31:0] val_rm_in,
  input  logic [3:0]  dst_in,
  output logic        wb_en_out,
  output logic        mem_read_out,
  output logic [31:0] alu_res_out,
  output logic [31:0] mem_data_out,
  output logic [3:0]  dst_out,
  output logic        ready
`ifdef MEM_BOUNDS_CHECK_EN
  ,
  output logic        mem_err
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Counter value in the final WAIT cycle; the IDLE request cycle is the
  // first of the WAIT_CYCLES stalled cycles, so WAIT lasts WAIT_CYCLES-1.
  localparam logic [3:0] LAST_CNT = (WAIT_CYCLES >= 2) ? 4'(WAIT_CYCLES - 2) : 4'd0;

  mem_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic          req;
  logic          access_done;
  logic          addr_bad;
  logic          mem_we;
  logic [AW-1:0] word_idx;
  logic [31:0]   rdata;

  assign req         = mem_read_in | mem_write_in;
  assign word_idx    = AW'((alu_res_in - 32'(BASE_ADDR)) >> 2);
  assign access_done = req & ready & ~rst;

`ifdef MEM_BOUNDS_CHECK_EN
  logic mem_err_q, mem_err_d;

  assign addr_bad = (alu_res_in < 32'(BASE_ADDR)) ||
                    (alu_res_in >= 32'(BASE_ADDR + 4 * DEPTH)) ||
                    (alu_res_in[1:0] != 2'b00);
  assign mem_err_d = access_done & addr_bad;
  assign mem_err   = mem_err_q;

  // Flag a bad access for one cycle after it completes
  always_ff @(posedge clk) begin
    if (rst) mem_err_q <= 1'b0;
    else     mem_err_q <= mem_err_d;
  end
`else
  assign addr_bad = 1'b0;
`endif

  // Next-state and counter logic for the wait-state sequencer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (WAIT_CYCLES != 0) begin
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            cnt_d   = 4'd0;
            state_d = (WAIT_CYCLES == 1) ? ST_DONE : ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == LAST_CNT) state_d = ST_DONE;
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Ready: high for non-memory ops, and only in the last cycle of an access
  always_comb begin
    ready = 1'b1;
    if (WAIT_CYCLES != 0) begin
      if (rst) begin
        ready = ~req;
      end else begin
        case (state_q)
          ST_IDLE: ready = ~req;
          ST_WAIT: ready = 1'b0;
          ST_DONE: ready = 1'b1;
          default: ready = 1'b1;
        endcase
      end
    end
  end

  assign mem_we = mem_write_in & access_done & ~addr_bad;

  data_memory #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_data_memory (
    .clk   (clk),
    .we    (mem_we),
    .addr  (word_idx),
    .wdata (val_rm_in),
    .rdata (rdata)
  );

  assign mem_data_out = (mem_read_in & ~addr_bad) ? rdata : 32'd0;
  assign wb_en_out    = wb_en_in & ready & ~rst;
  assign mem_read_out = mem_read_in;
  assign alu_res_out  = alu_res_in;
  assign dst_out      = dst_in;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: one instance with 3 wait states and one with none.
// A select flag routes memory requests to one instance at a time; the other
// sees only non-memory traffic. A per-instance word array models memory.
module tb_mem_stage;

  localparam int W     = 3;
  localparam int BASE  = 1024;
  localparam int DEPTH = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sel;
  logic        wb_en_in, mem_read_in, mem_write_in;
  logic [31:0] alu_res_in, val_rm_in;
  logic [3:0]  dst_in;

  logic        a_rd, a_wr, z_rd, z_wr;
  logic        a_wb_en_out, a_mem_read_out, a_ready;
  logic [31:0] a_alu_res_out, a_mem_data_out;
  logic [3:0]  a_dst_out;
  logic        z_wb_en_out, z_mem_read_out, z_ready;
  logic [31:0] z_alu_res_out, z_mem_data_out;
  logic [3:0]  z_dst_out;

  assign a_rd = mem_read_in  & ~sel;
  assign a_wr = mem_write_in & ~sel;
  assign z_rd = mem_read_in  & sel;
  assign z_wr = mem_write_in & sel;

  mem_stage #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .wb_en_in     (wb_en_in),
    .mem_read_in  (a_rd),
    .mem_write_in (a_wr),
    .alu_res_in   (alu_res_in),
    .val_rm_in    (val_rm_in),
    .dst_in       (dst_in),
    .wb_en_out    (a_wb_en_out),
    .mem_read_out (a_mem_read_out),
    .alu_res_out  (a_alu_res_out),
    .mem_data_out (a_mem_data_out),
    .dst_out      (a_dst_out),
    .ready        (a_ready)
  );

  mem_stage #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) dut0 (
    .clk          (clk),
    .rst          (rst),
    .wb_en_in     (wb_en_in),
    .mem_read_in  (z_rd),
    .mem_write_in (z_wr),
    .alu_res_in   (alu_res_in),
    .val_rm_in    (val_rm_in),
    .dst_in       (dst_in),
    .wb_en_out    (z_wb_en_out),
    .mem_read_out (z_mem_read_out),
    .alu_res_out  (z_alu_res_out),
    .mem_data_out (z_mem_data_out),
    .dst_out      (z_dst_out),
    .ready        (z_ready)
  );

  logic        m_ready, m_wb_en_out, m_mem_read_out;
  logic [31:0] m_alu_res_out, m_mem_data_out;
  logic [3:0]  m_dst_out;
  assign m_ready        = sel ? z_ready        : a_ready;
  assign m_wb_en_out    = sel ? z_wb_en_out    : a_wb_en_out;
  assign m_mem_read_out = sel ? z_mem_read_out : a_mem_read_out;
  assign m_alu_res_out  = sel ? z_alu_res_out  : a_alu_res_out;
  assign m_mem_data_out = sel ? z_mem_data_out : a_mem_data_out;
  assign m_dst_out      = sel ? z_dst_out      : a_dst_out;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_mem [2][DEPTH];
  bit          model_vld [2][DEPTH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'(BASE);
    return int'((off >> 2) % 32'(DEPTH));
  endfunction

  // ---------------- driver ----------------
  // Drive one operation and hold it until the expected completion cycle,
  // checking every output in every cycle of the access.
  task automatic run_op(input bit wb, input bit rd, input bit wr,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] dst);
    int  n, idx, m;
    bit  rdy, has_exp;
    m = sel ? 1 : 0;
    @(posedge clk); #1;
    wb_en_in     = wb;
    mem_read_in  = rd;
    mem_write_in = wr;
    alu_res_in   = addr;
    val_rm_in    = data;
    dst_in       = dst;
    n       = (rd || wr) ? ((sel ? 0 : W) + 1) : 1;
    idx     = idx_of(addr);
    has_exp = 1'b0;
    if (rd && model_vld[m][idx]) begin
      exp_q.push_back(model_mem[m][idx]);
      has_exp = 1'b1;
    end
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      rdy = (k == n);
      check("ready",        32'(m_ready),        32'(rdy));
      check("wb_en_out",    32'(m_wb_en_out),    32'(wb & rdy));
      check("mem_read_out", 32'(m_mem_read_out), 32'(rd));
      check("alu_res_out",  m_alu_res_out,       addr);
      check("dst_out",      32'(m_dst_out),      32'(dst));
      if (!rd)          check("mem_data_zero", m_mem_data_out, 32'd0);
      else if (has_exp) check("load_data",     m_mem_data_out, exp_q[0]);
    end
    if (has_exp) void'(exp_q.pop_front());
    if (wr) begin
      model_mem[m][idx] = data;
      model_vld[m][idx] = 1'b1;
    end
  endtask

  task automatic run_random(input int count);
    logic [31:0] addr;
    bit rd, wr;
    for (int i = 0; i < count; i++) begin
      case ($urandom_range(0, 3))
        0:       addr = $urandom();
        1:       addr = 32'(BASE + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(0, 3));
        default: addr = 32'(BASE + 4 * $urandom_range(0, DEPTH - 1));
      endcase
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      run_op(1'($urandom_range(0, 1)), rd, wr, addr, $urandom(), 4'($urandom_range(0, 15)));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    sel = 1'b0; rst = 1'b1;
    wb_en_in = 1'b1; mem_read_in = 1'b0; mem_write_in = 1'b0;
    alu_res_in = 32'd0; val_rm_in = 32'd0; dst_in = 4'd0;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < DEPTH; i++) model_vld[s][i] = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready",     32'(a_ready),     32'd1);
    check("rst_wb_en_out", 32'(a_wb_en_out), 32'd0);
    check("rst_mem_data",  a_mem_data_out,   32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Non-memory pass-through, store, load back
    run_op(1'b1, 1'b0, 1'b0, 32'h2A, 32'd0, 4'd5);
    run_op(1'b1, 1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 4'd2);
    run_op(1'b1, 1'b1, 1'b0, 32'd1032, 32'd0, 4'd7);
    check("load_1032_direct", m_mem_data_out, 32'hDEADBEEF);

    // Back-to-back stores, then read both
    run_op(1'b0, 1'b0, 1'b1, 32'd1024, 32'h11112222, 4'd1);
    run_op(1'b0, 1'b0, 1'b1, 32'd1028, 32'h33334444, 4'd1);
    run_op(1'b1, 1'b1, 1'b0, 32'd1024, 32'd0, 4'd3);
    check("load_1024_direct", m_mem_data_out, 32'h11112222);
    run_op(1'b1, 1'b1, 1'b0, 32'd1028, 32'd0, 4'd4);
    check("load_1028_direct", m_mem_data_out, 32'h33334444);

    // Store abandoned by reset in the second WAIT cycle
    run_op(1'b0, 1'b0, 1'b1, 32'd1036, 32'h12345678, 4'd0);
    @(posedge clk); #1;
    wb_en_in = 1'b1; mem_read_in = 1'b0; mem_write_in = 1'b1;
    alu_res_in = 32'd1036; val_rm_in = 32'h5555AAAA; dst_in = 4'd6;
    @(negedge clk);
    check("abort_c1_ready", 32'(a_ready), 32'd0);
    @(negedge clk);
    check("abort_c2_ready", 32'(a_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("abort_rst_ready", 32'(a_ready),     32'd0);
    check("abort_rst_wb_en", 32'(a_wb_en_out), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; mem_write_in = 1'b0;
    @(negedge clk);
    check("abort_idle_ready", 32'(a_ready), 32'd1);
    run_op(1'b1, 1'b1, 1'b0, 32'd1036, 32'd0, 4'd6);
    check("abort_word3", m_mem_data_out, 32'h12345678);

    // Load+store together shows pre-write data, then the new value
    run_op(1'b1, 1'b1, 1'b1, 32'd1032, 32'hA5A5A5A5, 4'd9);
    run_op(1'b1, 1'b1, 1'b0, 32'd1032, 32'd0, 4'd9);
    check("rdwr_then_load", m_mem_data_out, 32'hA5A5A5A5);

    run_random(40);

    // Zero wait states
    sel = 1'b1;
    run_op(1'b1, 1'b0, 1'b1, 32'd1040, 32'hCAFEF00D, 4'd3);
    run_op(1'b1, 1'b1, 1'b0, 32'd1040, 32'd0, 4'd3);
    check("w0_load_1040", m_mem_data_out, 32'hCAFEF00D);
    run_random(30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
